// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply controller.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWrite,
    StDone
  } state_e;

  // Wide enough to hold N products of two DATA_WIDTH operands without overflow.
  function automatic int unsigned acc_width(int unsigned data_width, int unsigned n);
    return 2 * data_width + $clog2(n);
  endfunction

  // Row-major element address.
  function automatic int unsigned compose_addr(int unsigned row, int unsigned col,
                                               int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with clear-on-first and C_WIDTH reduction of the result.
// MATMUL_SATURATE_EN selects clamping instead of two's-complement wrap.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned C_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  first,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [C_WIDTH-1:0]    c_out
);

  localparam int unsigned AccWidth = acc_width(DATA_WIDTH, N);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AccWidth-1:0]     acc_q, acc_base, acc_sum;
  logic        [C_WIDTH-1:0]      c_q, c_red;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    acc_base = first ? '0 : acc_q;
    acc_sum  = acc_base + AccWidth'(prod);
  end

`ifdef MATMUL_SATURATE_EN
  if (AccWidth > C_WIDTH) begin : g_sat
    localparam logic signed [AccWidth-1:0] SatMax =
        {{(AccWidth - C_WIDTH + 1){1'b0}}, {(C_WIDTH - 1){1'b1}}};
    localparam logic signed [AccWidth-1:0] SatMin =
        {{(AccWidth - C_WIDTH + 1){1'b1}}, {(C_WIDTH - 1){1'b0}}};
    always_comb begin
      c_red = acc_sum[C_WIDTH-1:0];
      if (acc_sum > SatMax) begin
        c_red = SatMax[C_WIDTH-1:0];
      end else if (acc_sum < SatMin) begin
        c_red = SatMin[C_WIDTH-1:0];
      end
    end
  end else begin : g_pass
    assign c_red = C_WIDTH'(acc_sum);
  end
`else
  // Truncates when the accumulator is wider, sign-extends when narrower.
  assign c_red = C_WIDTH'(acc_sum);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      c_q   <= '0;
    end else if (en) begin
      acc_q <= acc_sum;
      if (last) begin
        c_q <= c_red;
      end
    end
  end

  assign c_out = c_q;

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over three block RAMs; FSM, counters and registered addresses.
// Optional build macro MATMUL_SATURATE_EN clamps C results instead of wrapping.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned C_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [DATA_WIDTH-1:0] a_dout,
  output logic [ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [DATA_WIDTH-1:0] b_dout,
  output logic [ADDR_WIDTH-1:0] c_wr_addr,
  output logic                  c_wr_en,
  output logic [C_WIDTH-1:0]    c_din
);

  localparam int unsigned CntWidth = $clog2(N);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(N - 1);

  state_e state_q, state_d;
  logic [CntWidth-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        k_d = k_q + CntWidth'(1);
        if (k_q == CntLast) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        j_d = j_q + CntWidth'(1);
        if (j_q == CntLast) begin
          i_d = i_q + CntWidth'(1);
        end
        state_d = (i_q == CntLast && j_q == CntLast) ? StDone : StRun;
      end
      StDone: begin
        state_d = StIdle;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
      end
      default: state_d = StIdle;
    endcase

    // Addresses are registered one edge ahead so the BRAM sees them for the whole cycle.
    if (state_d == StRun) begin
      a_addr_d = ADDR_WIDTH'(compose_addr(32'(i_d), 32'(k_d), N));
      b_addr_d = ADDR_WIDTH'(compose_addr(32'(k_d), 32'(j_d), N));
    end
    if (state_d == StWrite) begin
      c_addr_d = ADDR_WIDTH'(compose_addr(32'(i_d), 32'(j_d), N));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
    end
  end

  matmul_mac #(
    .N         (N),
    .DATA_WIDTH(DATA_WIDTH),
    .C_WIDTH   (C_WIDTH)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .en   (state_q == StRun),
    .first(k_q == '0),
    .last (k_q == CntLast),
    .a    (a_dout),
    .b    (b_dout),
    .c_out(c_din)
  );

  assign busy      = (state_q == StRun) || (state_q == StWrite);
  assign done      = (state_q == StDone);
  assign c_wr_en   = (state_q == StWrite);
  assign a_rd_addr = a_addr_q;
  assign b_rd_addr = b_addr_q;
  assign c_wr_addr = c_addr_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: three instances (N = 2, 4, 8) with behavioural BRAMs and a
// matrix-product reference model.
module tb_matmul_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic       start     [3];
  logic       busy      [3];
  logic       done      [3];
  logic       c_wr_en   [3];
  logic [9:0] a_rd_addr [3];
  logic [9:0] b_rd_addr [3];
  logic [9:0] c_wr_addr [3];
  logic [7:0] a_dout    [3];
  logic [7:0] b_dout    [3];
  logic [15:0] c_din    [3];

  logic signed [7:0] mem_a [3][64];
  logic signed [7:0] mem_b [3][64];
  logic [15:0]       c_mem [3][64];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int wr_cnt [3];
  int seq [3];
  int done_cnt [3];
  int done_edge [3];
  int busy_cnt [3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    matmul_ctrl #(
      .N         (2 << g),
      .DATA_WIDTH(8),
      .ADDR_WIDTH(10),
      .C_WIDTH   (16)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .a_rd_addr(a_rd_addr[g]),
      .a_dout   (a_dout[g]),
      .b_rd_addr(b_rd_addr[g]),
      .b_dout   (b_dout[g]),
      .c_wr_addr(c_wr_addr[g]),
      .c_wr_en  (c_wr_en[g]),
      .c_din    (c_din[g])
    );

    // BRAM latches the address on the falling edge; data is ready at the next rising edge.
    always @(negedge clock) begin
      a_dout[g] <= mem_a[g][a_rd_addr[g][5:0]];
      b_dout[g] <= mem_b[g][b_rd_addr[g][5:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      wr_cnt[g] = 0; seq[g] = 0; done_cnt[g] = 0; done_edge[g] = 0; busy_cnt[g] = 0;
    end
  end

  // Monitor: C BRAM write port, done pulses and busy cycles.
  always @(negedge clock) begin
    for (int g = 0; g < 3; g++) begin
      if (reset) seq[g] = 0;
      if (busy[g]) busy_cnt[g]++;
      if (done[g]) begin
        done_cnt[g]++;
        done_edge[g] = cyc;
        seq[g] = 0;
      end
      if (c_wr_en[g]) begin
        check("wr_order", 32'(c_wr_addr[g]), 32'(seq[g]));
        c_mem[g][c_wr_addr[g][5:0]] = c_din[g];
        wr_cnt[g]++;
        seq[g]++;
      end
    end
  end

  function automatic logic [15:0] reduce(input int v);
`ifdef MATMUL_SATURATE_EN
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic int ref_elem(input int g, input int e);
    int n = 2 << g;
    int r = e / n;
    int c = e % n;
    int s = 0;
    for (int k = 0; k < n; k++) s += int'(mem_a[g][r*n+k]) * int'(mem_b[g][k*n+c]);
    return s;
  endfunction

  task automatic fill(input int g, input int av, input int bv);
    for (int e = 0; e < 64; e++) begin
      mem_a[g][e] = 8'(av);
      mem_b[g][e] = 8'(bv);
    end
  endtask

  task automatic run(input int g, input bit repulse);
    int n = 2 << g;
    int e0, w0, d0, b0, lim;
    @(negedge clock);
    w0 = wr_cnt[g]; d0 = done_cnt[g]; b0 = busy_cnt[g];
    start[g] = 1'b1;
    e0 = cyc + 1;
    @(negedge clock);
    start[g] = 1'b0;
    if (repulse) begin
      repeat (5) @(negedge clock);
      check("busy_mid", 32'(busy[g]), 32'd1);
      start[g] = 1'b1;
      @(negedge clock);
      start[g] = 1'b0;
    end
    lim = 0;
    while (done_cnt[g] == d0 && lim < 2000) begin
      @(posedge clock);
      lim++;
    end
    repeat (40) @(negedge clock);
    check("done_cnt", 32'(done_cnt[g] - d0), 32'd1);
    check("done_edge", 32'(done_edge[g]), 32'(e0 + n * n * (n + 1)));
    check("wr_cnt", 32'(wr_cnt[g] - w0), 32'(n * n));
    check("busy_cycles", 32'(busy_cnt[g] - b0), 32'(n * n * (n + 1)));
    for (int e = 0; e < n * n; e++) begin
      check($sformatf("c_elem%0d_n%0d", e, n), 32'(c_mem[g][e]), 32'(reduce(ref_elem(g, e))));
    end
  endtask

  task automatic load_test1;
    int av[4] = '{1, 2, 3, 4};
    int bv[4] = '{5, 6, 7, 8};
    for (int e = 0; e < 4; e++) begin
      mem_a[0][e] = 8'(av[e]);
      mem_b[0][e] = 8'(bv[e]);
    end
  endtask

  initial begin
    int w0, d0, lim;
    int av[4] = '{-1, 2, 3, -4};
    int iv[4] = '{1, 0, 0, 1};
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      fill(g, 0, 0);
    end
    repeat (3) @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      check("rst_busy", 32'(busy[g]), 32'd0);
      check("rst_done", 32'(done[g]), 32'd0);
      check("rst_wr_en", 32'(c_wr_en[g]), 32'd0);
      check("rst_a_addr", 32'(a_rd_addr[g]), 32'd0);
      check("rst_b_addr", 32'(b_rd_addr[g]), 32'd0);
      check("rst_c_addr", 32'(c_wr_addr[g]), 32'd0);
      check("rst_c_din", 32'(c_din[g]), 32'd0);
    end
    reset = 1'b0;

    // N=2 reference product, then A times identity.
    load_test1();
    run(0, 1'b0);
    check("t1_c00", 32'(c_mem[0][0]), 32'd19);
    check("t1_c11", 32'(c_mem[0][3]), 32'd50);
    for (int e = 0; e < 4; e++) begin
      mem_a[0][e] = 8'(av[e]);
      mem_b[0][e] = 8'(iv[e]);
    end
    run(0, 1'b0);
    check("t2_c00", 32'(c_mem[0][0]), 32'h0000ffff);
    check("t2_c11", 32'(c_mem[0][3]), 32'h0000fffc);

    // N=4 extremes; the second run re-pulses start mid-run.
    fill(1, 127, 127);
    run(1, 1'b0);
    fill(1, -128, 127);
    run(1, 1'b1);

    // Abort after the second write, then a clean rerun.
    load_test1();
    @(negedge clock);
    w0 = wr_cnt[0]; d0 = done_cnt[0];
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    lim = 0;
    while (wr_cnt[0] - w0 < 2 && lim < 200) begin
      @(posedge clock);
      lim++;
    end
    @(posedge clock);
    #2;
    check("busy_pre_rst", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("busy_async", 32'(busy[0]), 32'd0);
    check("wr_en_async", 32'(c_wr_en[0]), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("abort_writes", 32'(wr_cnt[0] - w0), 32'd2);
    check("abort_done", 32'(done_cnt[0] - d0), 32'd0);
    run(0, 1'b0);
    check("t1r_c01", 32'(c_mem[0][1]), 32'd22);
    check("t1r_c10", 32'(c_mem[0][2]), 32'd43);

    // N=8 random operands.
    for (int e = 0; e < 64; e++) begin
      mem_a[2][e] = 8'($urandom_range(0, 255));
      mem_b[2][e] = 8'($urandom_range(0, 255));
    end
    run(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
